// File: rtl/gdma_soft_rst_seq.sv
// Soft-reset sequencer for the GDMA clock domain.
// A new host reset request blocks command issue and drains outstanding reads and
// writes, giving up after a timeout. It then holds the channel datapath in reset
// for a fixed number of cycles, releases it, and toggles a completion flag back to
// the host side.
module gdma_soft_rst_seq #(
  parameter int unsigned OUTS_W        = 6,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic              gdma_clk,
  input  logic              gdma_rst,
  input  logic              h2gdma_rst,
  input  logic              rd_issue,
  input  logic              rd_done,
  input  logic              wr_issue,
  input  logic              wr_done,
  output logic              dma_block,
  output logic              chan_rst,
  output logic              rst_done_tgl,
  output logic              timeout_err,
  output logic [OUTS_W-1:0] rd_outs,
  output logic [OUTS_W-1:0] wr_outs
);

  localparam int unsigned TMO_W  = 16;
  localparam int unsigned HOLD_W = 8;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [OUTS_W-1:0] OUTS_MAX  = {OUTS_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                h2_dly_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [OUTS_W-1:0]   rd_q, rd_d;
  logic [OUTS_W-1:0]   wr_q, wr_d;
  logic                dma_block_q;
  logic                chan_rst_q;
  logic                tgl_q;
  logic                tmo_err_q;
  logic                req;
  logic                drained;
  logic                tmo_hit;
  logic                cnt_clr;

  // Saturating up/down count of one outstanding-transaction counter.
  function automatic logic [OUTS_W-1:0] cnt_next(input logic [OUTS_W-1:0] cnt,
                                                 input logic iss, input logic dn);
    logic [OUTS_W-1:0] res;
    res = cnt;
    if (iss && !dn && (cnt != OUTS_MAX)) begin
      res = cnt + OUTS_W'(1);
    end else if (dn && !iss && (cnt != '0)) begin
      res = cnt - OUTS_W'(1);
    end
    return res;
  endfunction

  assign req     = h2gdma_rst & ~h2_dly_q;
  assign drained = (rd_q == '0) && (wr_q == '0);
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next-state decode; a drained exit takes priority over the timeout exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = DRAIN;
      DRAIN:   if (drained || tmo_hit) state_d = HOLD;
      HOLD:    if (hold_q == HOLD_LAST) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters freeze at zero for every edge that starts in or enters HOLD.
  always_comb begin
    cnt_clr = (state_q == HOLD) || (state_d == HOLD);
    rd_d    = cnt_next(rd_q, rd_issue, rd_done);
    wr_d    = cnt_next(wr_q, wr_issue, wr_done);
    if (cnt_clr) begin
      rd_d = '0;
      wr_d = '0;
    end
  end

  // State, counters, timers and registered outputs.
  always_ff @(posedge gdma_clk or posedge gdma_rst) begin
    if (gdma_rst) begin
      state_q     <= IDLE;
      h2_dly_q    <= 1'b0;
      tmo_q       <= '0;
      hold_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      dma_block_q <= 1'b0;
      chan_rst_q  <= 1'b0;
      tgl_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h2_dly_q    <= h2gdma_rst;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      dma_block_q <= (state_d != IDLE);
      chan_rst_q  <= (state_d == HOLD);

      if ((state_q == IDLE) && req) begin
        tmo_q     <= '0;
        tmo_err_q <= 1'b0;
      end else if ((state_q == DRAIN) && !drained) begin
        if (tmo_hit) begin
          tmo_err_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end

      if ((state_q == DRAIN) && (state_d == HOLD)) begin
        hold_q <= '0;
      end else if (state_q == HOLD) begin
        hold_q <= hold_q + HOLD_W'(1);
      end

      if (state_q == RELEASE) begin
        tgl_q <= ~tgl_q;
      end
    end
  end

  assign dma_block    = dma_block_q;
  assign chan_rst     = chan_rst_q;
  assign rst_done_tgl = tgl_q;
  assign timeout_err  = tmo_err_q;
  assign rd_outs      = rd_q;
  assign wr_outs      = wr_q;

endmodule

// File: doc/gdma_soft_rst_seq.md
# gdma_soft_rst_seq

Soft-reset sequencer in the GDMA clock domain. It consumes the stretched host reset pulse `h2gdma_rst` produced by the host-to-GDMA reset stage. On each new request it blocks new DMA command issue and drains outstanding read/write transactions, with a timeout. It then holds the channel logic in reset for a fixed number of cycles, releases it, and reports completion to the host side with a toggle.

## Interface
- `OUTS_W`, 6: width of each outstanding-transaction counter.
- `DRAIN_TIMEOUT`, 1024: maximum cycles spent in DRAIN; range 1 to 2^16-1.
- `HOLD_CYCLES`, 16: cycles `chan_rst` is asserted; range 1 to 255.
- `gdma_clk`  in  1  GDMA clock.
- `gdma_rst`  in  1  reset, asynchronous, active-high; clock gdma_clk.
- `h2gdma_rst`  in  1  reset request, a multi-cycle level pulse synchronous to `gdma_clk`.
- `rd_issue`  in  1  one read command issued this cycle.
- `rd_done`  in  1  one read transaction completed this cycle.
- `wr_issue`  in  1  one write command issued this cycle.
- `wr_done`  in  1  one write transaction completed this cycle.
- `dma_block`  out  1  high: command issue logic must not issue new commands.
- `chan_rst`  out  1  synchronous reset to the DMA channel datapath.
- `rst_done_tgl`  out  1  toggles once per completed sequence; for the toggle synchroniser on the host side.
- `timeout_err`  out  1  last sequence left DRAIN by timeout.
- `rd_outs`  out  OUTS_W  outstanding read count.
- `wr_outs`  out  OUTS_W  outstanding write count.

## Operation
- Request detect: `req = h2gdma_rst & ~h2gdma_rst_d`. `h2gdma_rst_d` is a register that resets to 0.
- `req` is accepted only in IDLE. Rising edges in any other state are ignored and not queued.
- FSM states are IDLE, DRAIN, HOLD and RELEASE. The state register resets to IDLE.
- IDLE -> DRAIN on `req`.
  - Entering DRAIN clears `timeout_err` and the timeout counter.
- DRAIN -> HOLD when `rd_outs==0 && wr_outs==0`, evaluated on the registered counts.
  - Otherwise DRAIN -> HOLD when the timeout counter reaches `DRAIN_TIMEOUT-1`; this sets `timeout_err`.
  - If both conditions hold in the same cycle, the drained exit wins and `timeout_err` stays 0.
- HOLD lasts exactly HOLD_CYCLES cycles, then goes to RELEASE.
  - During HOLD both counters are forced to 0 and all issue/done strobes are ignored.
- RELEASE lasts 1 cycle, then goes to IDLE. `rst_done_tgl` flips on the RELEASE->IDLE edge.
- Outputs are decoded from registered state:
  - `dma_block` = (state != IDLE).
  - `chan_rst` = (state == HOLD).
- Counter rules, applied per counter in every state except HOLD:
  - issue and done in the same cycle: no change.
  - issue only: +1, saturating at 2^OUTS_W-1.
  - done only: -1, held at 0; underflow is ignored.
- Strobes arriving in DRAIN are still counted. Issue logic needs one cycle to observe `dma_block`.

## Timing
- Reset values: `dma_block`=0, `chan_rst`=0, `rst_done_tgl`=0, `timeout_err`=0, `rd_outs`=0, `wr_outs`=0. FSM in IDLE, timeout counter 0.
- `h2gdma_rst` first sampled high at edge N:
  - state is DRAIN after edge N.
  - `dma_block` is high from edge N onward.
- DRAIN with counts already 0 lasts 1 cycle. HOLD is entered at edge N+1.
- `chan_rst` is high from edge N+1 to edge N+1+HOLD_CYCLES.
- With zero outstanding: RELEASE runs during cycle N+1+HOLD_CYCLES; IDLE and the toggle occur at edge N+2+HOLD_CYCLES (N+18 with defaults).
- Worst-case drain: DRAIN occupies DRAIN_TIMEOUT cycles.
- `timeout_err` is set at the DRAIN->HOLD edge and holds until the next accepted `req`.
- `gdma_rst` mid-sequence: all state and outputs return to reset values asynchronously. `chan_rst` drops immediately and no toggle occurs.
- If `h2gdma_rst` is high when `gdma_rst` deasserts, a request is detected at the first clock edge.

## Test plan
- Idle request, zero outstanding, 9-cycle `h2gdma_rst` pulse at edge N:
  - `dma_block` high during N..N+17.
  - `chan_rst` high for exactly 16 cycles starting after N+1.
  - `rst_done_tgl` 0->1 at N+18; `timeout_err`=0.
- Drain: 3 `rd_issue` and 2 `wr_issue` before the request, then one done strobe every 5 cycles:
  - HOLD is entered the cycle after the fifth done.
  - counts step 3->0 and 2->0; no timeout.
- Timeout with DRAIN_TIMEOUT=8 and one read that never completes:
  - HOLD is entered after 8 DRAIN cycles; `timeout_err`=1.
  - `rd_outs` is 0 after HOLD entry.
  - the next request clears `timeout_err`.
- Counter edges:
  - simultaneous `rd_issue`+`rd_done` keeps the count.
  - `rd_done` at 0 stays 0.
  - 70 issues with OUTS_W=6 saturate at 63.
  - strobes during HOLD are ignored.
- Second `h2gdma_rst` rise during HOLD: ignored, exactly one toggle. A rise after return to IDLE starts a new sequence.
- `gdma_rst` asserted mid-HOLD: `chan_rst`, `dma_block` and the counters are 0 immediately. `rst_done_tgl` is unchanged at 0.
